// File: rtl/bcd_pkg.sv
// Shared BCD digit types, limits and next-value helpers used by the counter
// and its per-digit cells.
package bcd_pkg;

    localparam int unsigned BCD_DIGIT_W = 4;
    localparam logic [3:0]  BCD_MAX     = 4'd9;

    typedef logic [BCD_DIGIT_W-1:0] bcd_digit_t;

    // Codes at or above 9 (including illegal A-F) roll to 0 with a carry.
    function automatic logic bcd_is_top(input bcd_digit_t d);
        return (d >= BCD_MAX);
    endfunction

    function automatic bcd_digit_t bcd_next(input bcd_digit_t d);
        return bcd_is_top(d) ? 4'd0 : (d + 4'd1);
    endfunction

endpackage

// File: rtl/bcd_digit.sv
// One BCD decade cell: increments on cin, carries out combinationally when
// the cell is about to roll over.
module bcd_digit
    import bcd_pkg::*;
(
    input  logic       clk_100,
    input  logic       rst_n,
    input  logic       cin,
    output bcd_digit_t q,
    output logic       cout
);

    bcd_digit_t q_r;

    // Digit register with asynchronous clear.
    always_ff @(posedge clk_100 or negedge rst_n) begin
        if (!rst_n) begin
            q_r <= 4'd0;
        end else if (cin) begin
            q_r <= bcd_next(q_r);
        end else begin
            q_r <= q_r;
        end
    end

    assign q    = q_r;
    assign cout = cin & bcd_is_top(q_r);

endmodule

// File: rtl/bcd_counter.sv
// Cascadable NUM_DIGITS-digit BCD up-counter built as a ripple-enable chain
// of decade cells; cout_t fires in the cycle of the wrapping increment.
module bcd_counter
    import bcd_pkg::*;
#(
    parameter int unsigned NUM_DIGITS = 3
) (
    input  logic                        clk_100,
    input  logic                        rst_n,
    input  logic                        cin_t,
    output logic                        cout_t,
    output logic [4*NUM_DIGITS-1:0]     q_t
);

    logic [NUM_DIGITS:0] carry_s;

    assign carry_s[0] = cin_t;

    // Each cell is enabled by the carry of all lower cells.
    for (genvar g = 0; g < NUM_DIGITS; g++) begin : g_digit
        bcd_digit u_digit (
            .clk_100 (clk_100),
            .rst_n   (rst_n),
            .cin     (carry_s[g]),
            .q       (q_t[g*BCD_DIGIT_W +: BCD_DIGIT_W]),
            .cout    (carry_s[g+1])
        );
    end

    assign cout_t = carry_s[NUM_DIGITS];

endmodule

// File: tb/tb_bcd_counter.sv
// Self-checking bench: integer reference count checked against the DUT
// every cycle, plus directed scenarios with literal expectations.
module tb_bcd_counter;

    logic        clk_100 = 1'b0;
    logic        rst_n;
    logic        cin_t;
    logic        cout_t;
    logic [11:0] q_t;

    int          model_cnt;
    int          n_checks = 0;
    int          n_fail   = 0;
    int          cout_seen = 0;
    logic [11:0] cout_q = 12'h000;

    bcd_counter #(.NUM_DIGITS(3)) dut (
        .clk_100 (clk_100),
        .rst_n   (rst_n),
        .cin_t   (cin_t),
        .cout_t  (cout_t),
        .q_t     (q_t)
    );

    always #5 clk_100 = ~clk_100;

    function automatic logic [11:0] to_bcd(input int v);
        return {4'(v / 100), 4'((v / 10) % 10), 4'(v % 10)};
    endfunction

    task automatic chk(input string name, input logic [11:0] act, input logic [11:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference: decimal count modulo 1000 with asynchronous clear.
    always @(posedge clk_100 or negedge rst_n) begin
        if (!rst_n)     model_cnt <= 0;
        else if (cin_t) model_cnt <= (model_cnt + 1) % 1000;
    end

    // Compare DUT against the reference away from the active edge.
    always @(negedge clk_100) begin
        chk("q_vs_model", q_t, to_bcd(model_cnt));
        chk("cout_vs_model", {11'd0, cout_t},
            {11'd0, (rst_n === 1'b1) && (cin_t === 1'b1) && (model_cnt == 999)});
        for (int i = 0; i < 3; i++)
            if (q_t[i*4 +: 4] > 4'd9) chk("nibble_legal", {8'd0, q_t[i*4 +: 4]}, 12'h009);
        if (cout_t === 1'b1) begin
            cout_seen++;
            cout_q = q_t;
        end
    end

    task automatic tick();
        @(posedge clk_100);
        #1;
    endtask

    task automatic pulses(input int n);
        for (int i = 0; i < n; i++) begin
            cin_t = 1'b1;
            tick();
            cin_t = 1'b0;
        end
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
    endtask

    initial begin
        rst_n = 1'b0;
        cin_t = 1'b0;
        // Reset held with cin toggling.
        for (int i = 0; i < 6; i++) begin
            cin_t = ~cin_t;
            tick();
        end
        cin_t = 1'b0;
        chk("reset_hold_q", q_t, 12'h000);
        rst_n = 1'b1;
        pulses(3);
        chk("pre_async_q", q_t, 12'h003);
        #2 rst_n = 1'b0;
        #1;
        chk("async_reset_q", q_t, 12'h000);
        chk("async_reset_cout", {11'd0, cout_t}, 12'h000);
        tick();
        rst_n = 1'b1;

        // Hold with cin low.
        repeat (20) tick();
        chk("hold_q", q_t, 12'h000);

        // Periodic carry-in: 100 pulses at 1-in-6 duty, then idle.
        cout_seen = 0;
        for (int r = 0; r < 100; r++) begin
            repeat (5) tick();
            pulses(1);
        end
        repeat (500) tick();
        chk("periodic_q", q_t, 12'h100);
        chk("periodic_no_cout", 12'(cout_seen), 12'h000);

        // Digit rollovers.
        do_reset();
        pulses(9);
        chk("units_9", q_t, 12'h009);
        pulses(1);
        chk("units_roll", q_t, 12'h010);
        pulses(89);
        chk("tens_99", q_t, 12'h099);
        pulses(1);
        chk("tens_roll", q_t, 12'h100);

        // Full wrap with cin held high.
        do_reset();
        cout_seen = 0;
        cin_t = 1'b1;
        repeat (1000) tick();
        cin_t = 1'b0;
        chk("wrap_q", q_t, 12'h000);
        chk("wrap_cout_count", 12'(cout_seen), 12'h001);
        chk("wrap_cout_at_999", cout_q, 12'h999);

        // Mid-count reset.
        do_reset();
        cin_t = 1'b1;
        repeat (457) tick();
        chk("mid_457", q_t, 12'h457);
        #2 rst_n = 1'b0;
        #1;
        chk("mid_reset_q", q_t, 12'h000);
        tick();
        cin_t = 1'b0;
        rst_n = 1'b1;
        tick();
        chk("post_reset_hold", q_t, 12'h000);
        pulses(1);
        chk("post_reset_first", q_t, 12'h001);
        repeat (3) tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/bcd_counter.md
Name: bcd_counter

Overview:
- Three-digit (000–999) synchronous BCD up-counter.
- Advances by one on each clk_100 rising edge where the low-order carry-in cin_t is high.
- Emits a carry-out, cout_t, so several instances can be cascaded into wider decimal counters.
- Used as a decimal event/time accumulator fed by a lower-order counter or prescaler.

Parameters:
- NUM_DIGITS, 3, number of BCD digits; q_t width = 4*NUM_DIGITS. Default 3 gives 12 bits, range 0–999.

Ports:
- clk_100  input  1  system clock, 100 MHz (10 ns period), rising-edge active
- rst_n  input  1  asynchronous active-low reset
- cin_t  input  1  count enable / carry-in from the lower-order stage
- cout_t  output  1  carry-out to the higher-order stage
- q_t  output  12  packed BCD count; [3:0] units, [7:4] tens, [11:8] hundreds

Behaviour:
- Clocking and reset
  - One clock (clk_100).
  - Reset is asynchronous and active-low (rst_n).
  - rst_n low forces q_t = 12'h000 immediately, regardless of the clock, and therefore cout_t = 0.
  - Release of rst_n takes effect on the next clk_100 rising edge; no synchronizer inside the block.
  - Reset asserted mid-count clears to 000 at once; no pending increment survives reset.
- Counting (on clk_100 rising edge, rst_n high)
  - cin_t = 0: q_t holds.
  - cin_t = 1: q_t increments by one in decimal.
  - Units digit: 0..8 → +1; 9 → 0 and generates an internal carry to tens.
  - Tens digit: increments only when units = 9 and cin_t = 1; 9 → 0 and carries to hundreds.
  - Hundreds digit: increments only when units = 9, tens = 9 and cin_t = 1.
  - Wrap-around: 999 with cin_t = 1 → 000 on the next edge.
- Carry-out
  - cout_t is combinational: cout_t = cin_t AND (q_t == 12'h999).
  - cout_t is high during the same cycle as the wrapping increment, so a cascaded stage increments on the same edge.
  - Latency 0 cycles from cin_t to cout_t; 1 cycle from cin_t to q_t update.
- Digit legality
  - Each digit is always in the range 0–9.
  - Codes A–F are never produced.
  - If an illegal code is ever present, the next increment maps that digit to 0 with carry (self-recovering).
- Input timing
  - cin_t may be held high for many consecutive cycles; the counter then increments every cycle.
  - cin_t is sampled synchronously only; no edge detection.
- Outputs
  - q_t is registered and glitch-free.
  - cout_t is combinational and must be sampled on clock edges only.

Decomposition:
- Shared package (bcd_pkg):
  - BCD_DIGIT_W = 4
  - BCD_MAX = 4'd9
  - typedef bcd_digit_t (logic [3:0])
- Sub-module bcd_digit: one 4-bit BCD cell.
  - Inputs: clk_100, rst_n, cin.
  - Outputs: q[3:0], cout = cin & (q == 9).
- bcd_counter instantiates NUM_DIGITS bcd_digit cells in a ripple-enable chain.
  - Each cell's cin is the previous cell's cout.
  - cout_t is the last cell's cout.

Test Plan:
- Reset: hold rst_n = 0 with cin_t toggling, then assert rst_n low asynchronously mid-cycle → q_t = 12'h000 immediately; cout_t = 0.
- Hold: cin_t = 0 for 20 cycles after reset → q_t stays 12'h000.
- Periodic carry-in: cin_t high 1 cycle every 6 cycles (5 low, 1 high), 100 repetitions, then 500 idle cycles → q_t = 12'h100 at the end and stays there; cout_t never asserted.
- Digit rollover: preload to 12'h009 via 9 pulses, one more pulse → 12'h010. At 12'h099 plus one pulse → 12'h100.
- Full wrap: cin_t held high continuously for 1000 cycles from 000.
  - cout_t is high exactly in the cycle where q_t = 12'h999.
  - q_t = 12'h000 after cycle 1000.
  - No digit ever exceeds 9 (assertion on every nibble).
- Mid-count reset: at q_t = 12'h457 with cin_t = 1, pulse rst_n low → q_t = 12'h000 immediately; after release, the next cin_t pulse gives 12'h001.
